// File: rtl/ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_master_arbiter
// Purpose  : Two-master AHB-lite arbiter in front of an AHB-to-APB bridge port.
//            Round-robin with a beat limit; define ARB_FIXED_PRIO_EN to give
//            master 0 fixed priority instead.
// Revision : 1.0
// ============================================================================
module ahb_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Hbusreq0,
  input  logic                  Hbusreq1,
  input  logic [1:0]            Htrans0,
  input  logic [1:0]            Htrans1,
  input  logic [ADDR_WIDTH-1:0] Haddr0,
  input  logic [ADDR_WIDTH-1:0] Haddr1,
  input  logic                  Hwrite0,
  input  logic                  Hwrite1,
  input  logic [DATA_WIDTH-1:0] Hwdata0,
  input  logic [DATA_WIDTH-1:0] Hwdata1,
  output logic                  Hgrant0,
  output logic                  Hgrant1,
  output logic                  Hready_m,
  output logic [1:0]            Hresp0,
  output logic [1:0]            Hresp1,
  output logic [DATA_WIDTH-1:0] Hrdata_m,
  output logic [1:0]            Htrans,
  output logic [ADDR_WIDTH-1:0] Haddr,
  output logic                  Hwrite,
  output logic [DATA_WIDTH-1:0] Hwdata,
  output logic                  Hreadyin,
  input  logic                  Hreadyout,
  input  logic [1:0]            Hresp,
  input  logic [DATA_WIDTH-1:0] Hrdata
);

  typedef enum logic [1:0] {
    PARK = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [1:0] c_IDLE      = 2'b00;
  localparam logic [7:0] c_BURST_MAX = 8'(BURST_MAX);

  state_t     state_q;
  state_t     state_d;
  logic       gnt0_q;
  logic       gnt1_q;
  logic       downer_q;
  logic       dvalid_q;
  logic [7:0] count_q;
`ifndef ARB_FIXED_PRIO_EN
  logic       last_gnt_q;
`endif

  logic [1:0]            w_own_trans;
  logic [ADDR_WIDTH-1:0] w_own_addr;
  logic                  w_own_write;
  logic                  w_beat;
  logic [7:0]            w_count_inc;
  logic                  w_limit;
  logic                  w_switch;

  // Address-phase mux: only the current owner reaches the bridge.
  always_comb begin
    w_own_trans = c_IDLE;
    w_own_addr  = '0;
    w_own_write = 1'b0;
    case (state_q)
      GNT0: begin
        w_own_trans = Htrans0;
        w_own_addr  = Haddr0;
        w_own_write = Hwrite0;
      end
      GNT1: begin
        w_own_trans = Htrans1;
        w_own_addr  = Haddr1;
        w_own_write = Hwrite1;
      end
      default: ;
    endcase
  end

  // The limit counts the beat being accepted this cycle, so the switch is
  // decided on the BURST_MAX-th beat and that beat completes as the last one.
  assign w_beat      = w_own_trans[1];
  assign w_count_inc = (w_beat && (count_q != c_BURST_MAX)) ? count_q + 8'd1 : count_q;
  assign w_limit     = (w_count_inc == c_BURST_MAX);

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    state_d = state_q;
    if (Hreadyout) begin
      case (state_q)
        PARK: begin
          if (Hbusreq0)      state_d = GNT0;
          else if (Hbusreq1) state_d = GNT1;
        end
        GNT0: begin
          if (Hbusreq1 && (!Hbusreq0 || (Htrans0 == c_IDLE) || w_limit))
            state_d = GNT1;
          else if (!Hbusreq0 && (Htrans0 == c_IDLE))
            state_d = PARK;
        end
        GNT1: begin
          if (Hbusreq0)
            state_d = GNT0;
          else if (!Hbusreq1 && (Htrans1 == c_IDLE))
            state_d = PARK;
        end
        default: state_d = PARK;
      endcase
    end
  end
`else
  always_comb begin
    state_d = state_q;
    if (Hreadyout) begin
      case (state_q)
        PARK: begin
          if (Hbusreq0 && Hbusreq1)  state_d = last_gnt_q ? GNT0 : GNT1;
          else if (Hbusreq0)         state_d = GNT0;
          else if (Hbusreq1)         state_d = GNT1;
        end
        GNT0: begin
          if (Hbusreq1 && (!Hbusreq0 || (Htrans0 == c_IDLE) || w_limit))
            state_d = GNT1;
          else if (!Hbusreq0 && (Htrans0 == c_IDLE))
            state_d = PARK;
        end
        GNT1: begin
          if (Hbusreq0 && (!Hbusreq1 || (Htrans1 == c_IDLE) || w_limit))
            state_d = GNT0;
          else if (!Hbusreq1 && (Htrans1 == c_IDLE))
            state_d = PARK;
        end
        default: state_d = PARK;
      endcase
    end
  end
`endif

  assign w_switch = (state_d != state_q);

  // All arbitration state advances only on bridge-ready cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PARK;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      downer_q   <= 1'b0;
      dvalid_q   <= 1'b0;
      count_q    <= 8'd0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_q <= 1'b1;
`endif
    end else if (Hreadyout) begin
      state_q  <= state_d;
      gnt0_q   <= (state_d == GNT0);
      gnt1_q   <= (state_d == GNT1);
      downer_q <= (state_q == GNT1);
      dvalid_q <= w_beat;
      count_q  <= w_switch ? 8'd0 : w_count_inc;
`ifndef ARB_FIXED_PRIO_EN
      if (w_switch && (state_d != PARK))
        last_gnt_q <= (state_d == GNT1);
`endif
    end
  end

  assign Hgrant0  = gnt0_q;
  assign Hgrant1  = gnt1_q;
  assign Htrans   = w_own_trans;
  assign Haddr    = w_own_addr;
  assign Hwrite   = w_own_write;

  // Data phase follows the registered data-phase owner, not the grant.
  assign Hwdata   = dvalid_q ? (downer_q ? Hwdata1 : Hwdata0) : '0;
  assign Hresp0   = (dvalid_q && !downer_q) ? Hresp : 2'b00;
  assign Hresp1   = (dvalid_q &&  downer_q) ? Hresp : 2'b00;
  assign Hrdata_m = Hrdata;
  assign Hready_m = Hreadyout;
  assign Hreadyin = Hreadyout;

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_arbiter
// Purpose  : Directed vector bench for ahb_master_arbiter (BURST_MAX = 4).
// Revision : 1.0
// ============================================================================
module tb_ahb_master_arbiter;

  localparam logic [1:0]  IDL = 2'b00;
  localparam logic [1:0]  NSQ = 2'b10;
  localparam logic [1:0]  SQ  = 2'b11;
  localparam logic [1:0]  OK  = 2'b00;
  localparam logic [1:0]  ER  = 2'b01;
  localparam logic [31:0] A0  = 32'h8000_0010;
  localparam logic [31:0] D0  = 32'hA5A5_0001;
  localparam logic [31:0] A1  = 32'h8800_0000;
  localparam logic [31:0] D1  = 32'h5A5A_0002;
  localparam logic [31:0] JNK = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst;
  logic        Hbusreq0, Hbusreq1;
  logic [1:0]  Htrans0, Htrans1;
  logic [31:0] Haddr0, Haddr1;
  logic        Hwrite0, Hwrite1;
  logic [31:0] Hwdata0, Hwdata1;
  logic        Hgrant0, Hgrant1;
  logic        Hready_m;
  logic [1:0]  Hresp0, Hresp1;
  logic [31:0] Hrdata_m;
  logic [1:0]  Htrans;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;

  ahb_master_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BURST_MAX (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Hbusreq0 (Hbusreq0),
    .Hbusreq1 (Hbusreq1),
    .Htrans0  (Htrans0),
    .Htrans1  (Htrans1),
    .Haddr0   (Haddr0),
    .Haddr1   (Haddr1),
    .Hwrite0  (Hwrite0),
    .Hwrite1  (Hwrite1),
    .Hwdata0  (Hwdata0),
    .Hwdata1  (Hwdata1),
    .Hgrant0  (Hgrant0),
    .Hgrant1  (Hgrant1),
    .Hready_m (Hready_m),
    .Hresp0   (Hresp0),
    .Hresp1   (Hresp1),
    .Hrdata_m (Hrdata_m),
    .Htrans   (Htrans),
    .Haddr    (Haddr),
    .Hwrite   (Hwrite),
    .Hwdata   (Hwdata),
    .Hreadyin (Hreadyin),
    .Hreadyout(Hreadyout),
    .Hresp    (Hresp),
    .Hrdata   (Hrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, req0, req1;
    logic [1:0]  tr0;
    logic [31:0] a0;
    logic        w0;
    logic [31:0] d0;
    logic [1:0]  tr1;
    logic [31:0] a1;
    logic        w1;
    logic [31:0] d1;
    logic [1:0]  resp;
    logic        eg0, eg1;
    logic [1:0]  etr;
    logic [31:0] ea;
    logic        ewr;
    logic [31:0] ewd;
    logic [1:0]  er0, er1;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] ba(input int k);
    return 32'h8000_0100 + 32'(k * 4);
  endfunction

  function automatic logic [31:0] bd(input int k);
    return 32'hBEEF_0000 + 32'(k);
  endfunction

  task automatic add(input logic rs, input logic rdy, input logic r0, input logic r1,
                     input logic [1:0] t0, input logic [31:0] a0, input logic w0, input logic [31:0] d0,
                     input logic [1:0] t1, input logic [31:0] a1, input logic w1, input logic [31:0] d1,
                     input logic [1:0] rsp,
                     input logic g0, input logic g1, input logic [1:0] etr, input logic [31:0] ea,
                     input logic ewr, input logic [31:0] ewd, input logic [1:0] er0, input logic [1:0] er1);
    vec_t v;
    v.rst = rs;  v.rdy = rdy; v.req0 = r0; v.req1 = r1;
    v.tr0 = t0;  v.a0 = a0;   v.w0 = w0;   v.d0 = d0;
    v.tr1 = t1;  v.a1 = a1;   v.w1 = w1;   v.d1 = d1;
    v.resp = rsp;
    v.eg0 = g0;  v.eg1 = g1;  v.etr = etr; v.ea = ea;
    v.ewr = ewr; v.ewd = ewd; v.er0 = er0; v.er1 = er1;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] want);
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @vec %0d: got %h, want %h", nm, idx, act, want);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; Hreadyout = 1'b1; Hresp = OK; Hrdata = 32'h0;
    Hbusreq0 = 1'b0; Htrans0 = IDL; Haddr0 = '0; Hwrite0 = 1'b0; Hwdata0 = '0;
    Hbusreq1 = 1'b0; Htrans1 = IDL; Haddr1 = '0; Hwrite1 = 1'b0; Hwdata1 = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [31:0] rd;
    rd = 32'hC0DE_0000 + 32'(idx);
    rst = v.rst; Hreadyout = v.rdy; Hresp = v.resp; Hrdata = rd;
    Hbusreq0 = v.req0; Htrans0 = v.tr0; Haddr0 = v.a0; Hwrite0 = v.w0; Hwdata0 = v.d0;
    Hbusreq1 = v.req1; Htrans1 = v.tr1; Haddr1 = v.a1; Hwrite1 = v.w1; Hwdata1 = v.d1;
    #1;
    n_vec++;
    chk("Hgrant0",  idx, 32'(Hgrant0),  32'(v.eg0));
    chk("Hgrant1",  idx, 32'(Hgrant1),  32'(v.eg1));
    chk("Htrans",   idx, 32'(Htrans),   32'(v.etr));
    chk("Haddr",    idx, Haddr,         v.ea);
    chk("Hwrite",   idx, 32'(Hwrite),   32'(v.ewr));
    chk("Hwdata",   idx, Hwdata,        v.ewd);
    chk("Hresp0",   idx, 32'(Hresp0),   32'(v.er0));
    chk("Hresp1",   idx, 32'(Hresp1),   32'(v.er1));
    chk("Hready_m", idx, 32'(Hready_m), 32'(v.rdy));
    chk("Hreadyin", idx, 32'(Hreadyin), 32'(v.rdy));
    chk("Hrdata_m", idx, Hrdata_m,      rd);
  endtask

  initial begin
    idle_inputs();

    // rst rdy r0 r1 | tr0 a0 w0 d0 | tr1 a1 w1 d1 | resp || g0 g1 trans addr write wdata resp0 resp1
    // Reset, then a tie goes to master 0; master 0 idles and master 1 takes over.
    add(1,1,0,0, NSQ,A0,1,JNK, IDL,A1,0,JNK, OK, 0,0,IDL,0,0,0,OK,OK);
    add(0,1,0,0, NSQ,A0,1,JNK, IDL,A1,0,JNK, OK, 0,0,IDL,0,0,0,OK,OK);
    add(0,1,1,1, IDL,A0,0,JNK, IDL,A1,0,JNK, OK, 0,0,IDL,0,0,0,OK,OK);
    add(0,1,1,1, NSQ,A0,1,JNK, NSQ,A1,0,JNK, OK, 1,0,NSQ,A0,1,0,OK,OK);
    add(0,1,0,1, IDL,A0,0,D0,  NSQ,A1,0,JNK, OK, 1,0,IDL,A0,0,D0,OK,OK);
    // Master 1 read of 0x8800_0000 gets an ERROR response.
    add(0,1,0,1, IDL,A0,0,JNK, NSQ,A1,0,JNK, OK, 0,1,NSQ,A1,0,0,OK,OK);
    add(0,1,0,1, IDL,A0,0,JNK, IDL,A1,0,D1,  ER, 0,1,IDL,A1,0,D1,OK,ER);
    add(0,1,0,1, IDL,A0,0,JNK, IDL,A1,0,D1,  ER, 0,1,IDL,A1,0,0,OK,OK);
    add(0,1,0,0, IDL,A0,0,JNK, IDL,A1,0,D1,  OK, 0,1,IDL,A1,0,0,OK,OK);
    add(0,1,0,0, IDL,A0,0,JNK, IDL,A1,0,D1,  OK, 0,0,IDL,0,0,0,OK,OK);
    // Single request from PARK: NONSEQ write then its data phase.
    add(0,1,1,0, IDL,A0,0,JNK, IDL,A1,0,JNK, OK, 0,0,IDL,0,0,0,OK,OK);
    add(0,1,1,0, NSQ,A0,1,JNK, IDL,A1,0,JNK, OK, 1,0,NSQ,A0,1,0,OK,OK);
    add(0,1,0,0, IDL,A0,0,D0,  IDL,A1,0,JNK, OK, 1,0,IDL,A0,0,D0,OK,OK);
    // Round-robin tie now goes to master 1; it idles, master 0 takes over.
    add(0,1,1,1, IDL,A0,0,JNK, IDL,A1,0,JNK, OK, 0,0,IDL,0,0,0,OK,OK);
    add(0,1,1,1, IDL,A0,0,JNK, IDL,A1,0,JNK, OK, 0,1,IDL,A1,0,0,OK,OK);
    // Burst limit of 4 with master 1 waiting; one wait state mid-burst.
    add(0,1,1,1, NSQ,ba(0),1,JNK,   NSQ,A1,0,JNK, OK, 1,0,NSQ,ba(0),1,0,OK,OK);
    add(0,1,1,1, SQ, ba(1),1,bd(0), NSQ,A1,0,JNK, OK, 1,0,SQ, ba(1),1,bd(0),OK,OK);
    add(0,0,1,1, SQ, ba(2),1,bd(1), NSQ,A1,0,JNK, OK, 1,0,SQ, ba(2),1,bd(1),OK,OK);
    add(0,1,1,1, SQ, ba(2),1,bd(1), NSQ,A1,0,JNK, OK, 1,0,SQ, ba(2),1,bd(1),OK,OK);
    add(0,1,1,1, SQ, ba(3),1,bd(2), NSQ,A1,0,JNK, OK, 1,0,SQ, ba(3),1,bd(2),OK,OK);
    add(0,1,1,1, SQ, ba(4),1,bd(3), NSQ,A1,1,JNK, ER, 0,1,NSQ,A1,1,bd(3),ER,OK);
    add(0,1,1,0, NSQ,ba(4),1,JNK,   IDL,A1,0,D1,  OK, 0,1,IDL,A1,0,D1,OK,OK);
    // Handover held off by three wait states.
    add(0,1,1,1, NSQ,ba(4),1,JNK,   NSQ,A1,0,JNK, OK, 1,0,NSQ,ba(4),1,0,OK,OK);
    add(0,0,0,1, IDL,ba(4),0,bd(4), NSQ,A1,0,JNK, OK, 1,0,IDL,ba(4),0,bd(4),OK,OK);
    add(0,0,0,1, IDL,ba(4),0,bd(4), NSQ,A1,0,JNK, OK, 1,0,IDL,ba(4),0,bd(4),OK,OK);
    add(0,0,0,1, IDL,ba(4),0,bd(4), NSQ,A1,0,JNK, OK, 1,0,IDL,ba(4),0,bd(4),OK,OK);
    add(0,1,0,1, IDL,ba(4),0,bd(4), NSQ,A1,0,JNK, OK, 1,0,IDL,ba(4),0,bd(4),OK,OK);
    add(0,1,0,1, IDL,ba(4),0,JNK,   NSQ,A1,0,JNK, OK, 0,1,NSQ,A1,0,0,OK,OK);
    add(0,1,0,0, IDL,ba(4),0,JNK,   IDL,A1,0,D1,  OK, 0,1,IDL,A1,0,D1,OK,OK);
    add(0,1,0,0, IDL,ba(4),0,JNK,   IDL,A1,0,D1,  OK, 0,0,IDL,0,0,0,OK,OK);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i], i);
    end

    // Asynchronous reset in the middle of a master 1 burst (count = 3).
    @(negedge clk);
    idle_inputs();
    Hbusreq1 = 1'b1;
    #1; n_vec++;
    chk("rm_park_gnt1", 100, 32'(Hgrant1), 32'd0);

    @(negedge clk);
    Htrans1 = NSQ; Haddr1 = A1; Hwrite1 = 1'b1;
    #1; n_vec++;
    chk("rm_gnt1", 101, 32'(Hgrant1), 32'd1);

    @(negedge clk);
    Htrans1 = SQ; Haddr1 = A1 + 32'd4; Hwdata1 = D1;
    #1; n_vec++;
    chk("rm_seq_trans", 102, 32'(Htrans), 32'(SQ));

    @(negedge clk);
    Haddr1 = A1 + 32'd8;
    #1; n_vec++;
    chk("rm_seq_addr", 103, Haddr, A1 + 32'd8);

    @(negedge clk);
    Haddr1 = A1 + 32'd12; Hresp = ER;
    #1; n_vec++;
    chk("rm_pre_gnt1",  104, 32'(Hgrant1), 32'd1);
    chk("rm_pre_resp1", 104, 32'(Hresp1),  32'(ER));
    #2 rst = 1'b1;
    #1; n_vec++;
    chk("rm_rst_gnt1",  105, 32'(Hgrant1), 32'd0);
    chk("rm_rst_trans", 105, 32'(Htrans),  32'(IDL));
    chk("rm_rst_addr",  105, Haddr,        32'd0);
    chk("rm_rst_wdata", 105, Hwdata,       32'd0);
    chk("rm_rst_resp1", 105, 32'(Hresp1),  32'(OK));

    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1; n_vec++;
      chk("rm_post_gnt0", 106 + k, 32'(Hgrant0), 32'd0);
      chk("rm_post_gnt1", 106 + k, 32'(Hgrant1), 32'd0);
    end

    @(negedge clk);
    Hbusreq0 = 1'b1; Hbusreq1 = 1'b1;
    #1; n_vec++;
    chk("rm_req_gnt0", 109, 32'(Hgrant0), 32'd0);
    @(negedge clk);
    #1; n_vec++;
    chk("rm_tie_gnt0", 110, 32'(Hgrant0), 32'd1);
    chk("rm_tie_gnt1", 110, 32'(Hgrant1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
